// File: rtl/cm3_reset_pkg.sv
// Shared types for the Cortex-M3 reset controller: FSM states and reset-cause codes.
// Latency: n/a (types only).
// Backpressure: n/a.
package cm3_reset_pkg;

  // Width of the shared down-counter used by every hold phase
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    LOCK_WAIT = 2'd0,
    POR_HOLD  = 2'd1,
    SYS_HOLD  = 2'd2,
    RUN       = 2'd3
  } rst_state_e;

  typedef enum logic [1:0] {
    CAUSE_POR    = 2'd0,
    CAUSE_LOCK   = 2'd1,
    CAUSE_SYSREQ = 2'd2
  } rst_cause_e;

endpackage

// File: rtl/cdc_sync2.sv
// Two-flop synchronizer for a single asynchronous level into the hclk domain.
// Latency: 2 hclk cycles from input change to q.
// Backpressure: none; a level, sampled every cycle.
module cdc_sync2 (
  input  logic hclk,
  input  logic RESET,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw level through two flops; both clear on reset
  always_ff @(posedge hclk) begin
    if (RESET) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cm3_reset_ctrl.sv
// Reset sequencer for the M3 SoC: PLL-lock filter, PORESETn/HRESETn sequencing, debug power-up handshake.
// Latency: outputs are state-decoded registers, one hclk after each state change; lock loss reaches poreset_n in <=4 cycles.
// Backpressure: none; sysresetreq is a level that simply extends SYS_HOLD while high.
module cm3_reset_ctrl
  import cm3_reset_pkg::*;
#(
  parameter int LOCK_FILTER = 4,
  parameter int POR_CYCLES  = 255,
  parameter int SYS_CYCLES  = 16
) (
  input  logic       hclk,
  input  logic       RESET,
  input  logic       pll_locked,
  input  logic       sysresetreq,
  input  logic       cdbgpwrupreq,
  output logic       poreset_n,
  output logic       hreset_n,
  output logic       cdbgpwrupack,
  output logic [1:0] rst_cause
);

  // Counter compare/load values; the lock filter counts up, the hold phases count down to 1
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] POR_LOAD  = CNT_W'(POR_CYCLES);
  localparam logic [CNT_W-1:0] SYS_LOAD  = CNT_W'(SYS_CYCLES);

  rst_state_e       state;
  rst_cause_e       cause;
  logic [CNT_W-1:0] cnt;
  logic             lock_s;
  logic             dbgreq_s;
  logic             por_released;

  cdc_sync2 u_sync_lock (
    .hclk  (hclk),
    .RESET (RESET),
    .d     (pll_locked),
    .q     (lock_s)
  );

  cdc_sync2 u_sync_dbg (
    .hclk  (hclk),
    .RESET (RESET),
    .d     (cdbgpwrupreq),
    .q     (dbgreq_s)
  );

  // Value poreset_n takes at the coming edge; also gates the debug ack so it never outlives poreset_n
  assign por_released = (state == SYS_HOLD) || (state == RUN);

  assign rst_cause = cause;

  // Sequencer: state, shared counter, reset cause and the registered output decode
  always_ff @(posedge hclk) begin
    if (RESET) begin
      state        <= LOCK_WAIT;
      cnt          <= '0;
      cause        <= CAUSE_POR;
      poreset_n    <= 1'b0;
      hreset_n     <= 1'b0;
      cdbgpwrupack <= 1'b0;
    end else begin
      poreset_n    <= por_released;
      hreset_n     <= (state == RUN);
      // Ack rises only once poreset_n is already high, and drops with it
      cdbgpwrupack <= por_released && poreset_n && dbgreq_s;

      case (state)
        LOCK_WAIT: begin
          if (!lock_s) begin
            cnt <= '0;
          end else if (cnt >= LOCK_LAST) begin
            state <= POR_HOLD;
            cnt   <= POR_LOAD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        POR_HOLD: begin
          if (!lock_s) begin
            state <= LOCK_WAIT;
            cnt   <= '0;
            cause <= CAUSE_LOCK;
          end else if (cnt <= 1) begin
            state <= SYS_HOLD;
            cnt   <= SYS_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        SYS_HOLD: begin
          // Lock loss wins over a pending system reset request
          if (!lock_s) begin
            state <= LOCK_WAIT;
            cnt   <= '0;
            cause <= CAUSE_LOCK;
          end else if (sysresetreq) begin
            cnt <= SYS_LOAD;
          end else if (cnt <= 1) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        RUN: begin
          if (!lock_s) begin
            state <= LOCK_WAIT;
            cnt   <= '0;
            cause <= CAUSE_LOCK;
          end else if (sysresetreq) begin
            state <= SYS_HOLD;
            cnt   <= SYS_LOAD;
            cause <= CAUSE_SYSREQ;
          end
        end

        default: begin
          state <= LOCK_WAIT;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cm3_reset_ctrl.sv
// Self-checking bench for cm3_reset_ctrl: directed vector table, corner-case sequences, random run vs timestamp model.
// Latency: n/a.
// Backpressure: n/a.
module tb_cm3_reset_ctrl;

  localparam int LF   = 4;
  localparam int PORC = 8;
  localparam int SYSC = 4;

  localparam int PH_WAIT = 0;
  localparam int PH_POR  = 1;
  localparam int PH_SYS  = 2;
  localparam int PH_RUN  = 3;

  logic       hclk = 1'b0;
  logic       RESET = 1'b1;
  logic       pll_locked = 1'b0;
  logic       sysresetreq = 1'b0;
  logic       cdbgpwrupreq = 1'b0;
  logic       poreset_n;
  logic       hreset_n;
  logic       cdbgpwrupack;
  logic [1:0] rst_cause;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  cm3_reset_ctrl #(
    .LOCK_FILTER (LF),
    .POR_CYCLES  (PORC),
    .SYS_CYCLES  (SYSC)
  ) dut (
    .hclk         (hclk),
    .RESET        (RESET),
    .pll_locked   (pll_locked),
    .sysresetreq  (sysresetreq),
    .cdbgpwrupreq (cdbgpwrupreq),
    .poreset_n    (poreset_n),
    .hreset_n     (hreset_n),
    .cdbgpwrupack (cdbgpwrupack),
    .rst_cause    (rst_cause)
  );

  // Reference model: phase derived from timestamps (filter-met edge, system-release edge)
  int         m_cyc = 0;
  bit         m_s1, m_s2, m_d1, m_d2;
  bit         m_fv;
  int         m_f, m_h, m_run;
  int         m_st = PH_WAIT;
  bit         m_por, m_hr, m_ack;
  logic [1:0] m_cause = 2'd0;

  task automatic model_edge(input bit rst, input bit pll, input bit req, input bit dbg);
    bit ls;
    bit ds;
    bit por_old;
    int st_old;
    ls      = m_s2;
    ds      = m_d2;
    por_old = m_por;
    st_old  = m_st;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_d1 = 0; m_d2 = 0;
      m_fv = 0; m_run = 0; m_st = PH_WAIT;
      m_por = 0; m_hr = 0; m_ack = 0; m_cause = 2'd0;
    end else begin
      if (st_old != PH_WAIT && !ls) begin
        m_fv = 0; m_run = 0; m_cause = 2'd1;
      end else if (st_old == PH_WAIT) begin
        m_run = ls ? m_run + 1 : 0;
        if (m_run == LF) begin
          m_fv = 1; m_f = m_cyc; m_h = m_cyc + PORC + SYSC; m_run = 0;
        end
      end else if (req && st_old != PH_POR) begin
        m_h = m_cyc + SYSC;
        if (st_old == PH_RUN) m_cause = 2'd2;
      end
      if (!m_fv)                  m_st = PH_WAIT;
      else if (m_cyc < m_f + PORC) m_st = PH_POR;
      else if (m_cyc < m_h)        m_st = PH_SYS;
      else                         m_st = PH_RUN;
      m_por = (st_old == PH_SYS) || (st_old == PH_RUN);
      m_hr  = (st_old == PH_RUN);
      m_ack = m_por && por_old && ds;
      m_s2 = m_s1; m_s1 = pll;
      m_d2 = m_d1; m_d1 = dbg;
    end
    m_cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, advance, sample 1 ns after the edge, compare against the model
  task automatic tick(input bit rst, input bit pll, input bit req, input bit dbg);
    RESET = rst; pll_locked = pll; sysresetreq = req; cdbgpwrupreq = dbg;
    @(posedge hclk);
    #1;
    model_edge(rst, pll, req, dbg);
    chk($sformatf("model cyc%0d", m_cyc),
        {27'd0, poreset_n, hreset_n, cdbgpwrupack, rst_cause},
        {27'd0, m_por, m_hr, m_ack, m_cause});
  endtask

  typedef struct {
    int         n;
    bit         rst, pll, req, dbg;
    logic [4:0] exp;   // {poreset_n, hreset_n, cdbgpwrupack, rst_cause}
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input bit rst, input bit pll, input bit req, input bit dbg,
                     input bit por, input bit hr, input bit ack, input logic [1:0] c);
    vec_t v;
    v.n = n; v.rst = rst; v.pll = pll; v.req = req; v.dbg = dbg;
    v.exp = {por, hr, ack, c};
    tbl.push_back(v);
  endtask

  initial begin
    int lows;
    int b;
    int t;
    bit dbg_r;

    //   n  rst pll req dbg | por hr ack cause
    add( 2, 1, 1, 0, 1,   0, 0, 0, 2'd0);  // reset values
    add(14, 0, 1, 0, 1,   0, 0, 0, 2'd0);  // one edge before poreset_n release
    add( 1, 0, 1, 0, 1,   1, 0, 0, 2'd0);  // poreset_n high 15 edges after release
    add( 1, 0, 1, 0, 1,   1, 0, 1, 2'd0);  // ack the cycle after poreset_n
    add( 2, 0, 1, 0, 1,   1, 0, 1, 2'd0);  // still in SYS_HOLD
    add( 1, 0, 1, 0, 1,   1, 1, 1, 2'd0);  // hreset_n 4 edges after poreset_n
    add( 1, 0, 1, 1, 1,   1, 1, 1, 2'd2);  // sysresetreq pulse, cause latched
    add( 4, 0, 1, 0, 1,   1, 0, 1, 2'd2);  // last cycle of the 4-cycle hold
    add( 1, 0, 1, 0, 1,   1, 1, 1, 2'd2);  // released, cause held
    add( 2, 0, 1, 0, 0,   1, 1, 1, 2'd2);  // req dropped, ack still in pipe
    add( 1, 0, 1, 0, 0,   1, 1, 0, 2'd2);  // ack low 3 edges after req drop
    add( 1, 0, 0, 0, 0,   1, 1, 0, 2'd2);  // one-cycle lock drop
    add( 2, 0, 1, 0, 0,   1, 1, 0, 2'd1);  // state back to LOCK_WAIT, cause=1
    add( 1, 0, 1, 0, 0,   0, 0, 0, 2'd1);  // poreset_n low 3 edges after drop
    add( 2, 0, 0, 0, 1,   0, 0, 0, 2'd0 | 2'd1); // 2-cycle glitch at filter count 3, dbg raised
    add(14, 0, 1, 0, 1,   0, 0, 0, 2'd1);  // filter restarted: still in POR_HOLD
    add( 1, 0, 1, 0, 1,   1, 0, 0, 2'd1);  // poreset_n high, ack held off
    add( 1, 0, 1, 0, 1,   1, 0, 1, 2'd1);  // ack next cycle
    add( 3, 0, 1, 0, 1,   1, 1, 1, 2'd1);  // RUN again
    add( 2, 0, 0, 0, 1,   1, 1, 1, 2'd1);  // lock dropping, not yet synchronized
    add( 1, 0, 0, 1, 1,   1, 1, 1, 2'd1);  // req and lock loss together: lock wins
    add( 1, 0, 1, 0, 1,   0, 0, 0, 2'd1);  // full reset follows

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++)
        tick(tbl[i].rst, tbl[i].pll, tbl[i].req, tbl[i].dbg);
      chk($sformatf("vec%0d", i), {27'd0, poreset_n, hreset_n, cdbgpwrupack, rst_cause},
          {27'd0, tbl[i].exp});
    end

    // Wait for RUN again after the lock-loss re-sequence
    b = 0;
    while (hreset_n !== 1'b1 && b < 100) begin tick(0, 1, 0, 1); b++; end
    chk("reach run", {31'd0, hreset_n}, 32'd1);

    // Single-cycle request: hreset_n low for exactly SYS_CYCLES
    lows = 0;
    tick(0, 1, 1, 1); if (hreset_n !== 1'b1) lows++;
    for (int k = 0; k < 20; k++) begin tick(0, 1, 0, 1); if (hreset_n !== 1'b1) lows++; end
    chk("pulse low cycles", lows, SYSC);

    // Request raised in RUN and held through ten SYS_HOLD cycles: 4 + 10 low cycles
    lows = 0;
    for (int k = 0; k < 11; k++) begin tick(0, 1, 1, 1); if (hreset_n !== 1'b1) lows++; end
    for (int k = 0; k < 30; k++) begin tick(0, 1, 0, 1); if (hreset_n !== 1'b1) lows++; end
    chk("held low cycles", lows, SYSC + 10);
    chk("held cause", {30'd0, rst_cause}, 32'd2);

    // RESET mid-handshake during SYS_HOLD with request held
    b = 0;
    while (cdbgpwrupack !== 1'b1 && b < 50) begin tick(0, 1, 0, 1); b++; end
    tick(0, 1, 1, 1);
    tick(0, 1, 1, 1);
    chk("sys_hold entered", {30'd0, hreset_n, cdbgpwrupack}, 32'd1);
    tick(1, 1, 1, 1);
    chk("reset abort", {27'd0, poreset_n, hreset_n, cdbgpwrupack, rst_cause}, 32'd0);

    // Restart from LOCK_WAIT: poreset_n exactly 2+4+8+1 edges after release
    t = 0;
    do begin tick(0, 1, 0, 0); t++; end while (poreset_n !== 1'b1 && t < 40);
    chk("por rise edges", t, 2 + LF + PORC + 1);

    // Random run against the model
    dbg_r = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 14) == 0) dbg_r = ~dbg_r;
      tick($urandom_range(0, 499) == 0,
           $urandom_range(0, 39) != 0,
           $urandom_range(0, 24) == 0,
           dbg_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
